// File: rtl/q_time_scheduler.sv
// ---------------------------------------------------------------------------
// q_time_scheduler
//
// Pops timestamps from an external FIFO and fires each one when the global
// time counter reaches it. Ordering of a timestamp against t_cnt uses the
// modular difference (cur_time - t_cnt) mod 2^TW, so wrap-around of t_cnt
// needs no special handling: a difference of zero is "due", a difference
// with the top bit set is "late" (already in the past), anything else means
// keep waiting.
//
// Build option:
//   Q_LATE_DROP_EN  defined   -> late timestamps are dropped (counted only)
//                   undefined -> late timestamps are fired with fire_late=1
//
// Parameters:
//   TW  timestamp / time-counter width
//   CW  statistics counter width (counters saturate at 2^CW-1)
//
// Ports:
//   clk, reset    rising-edge clock, synchronous active-high reset
//   enable        permits fetching new timestamps (IDLE->POP, ISSUE->POP)
//   flush         drops any held timestamp and returns to IDLE
//   t_cnt         free-running global time counter
//   ts_empty      timestamp FIFO empty
//   ts_data       FIFO read data, valid the cycle after ts_rd_en
//   ts_rd_en      FIFO pop strobe (high for the single POP cycle)
//   fire_valid    timestamp due, held until fire_ready
//   fire_ready    downstream accepts the fire
//   fire_time     timestamp being fired
//   fire_late     fired timestamp was already past when evaluated
//   busy          high in every state except IDLE
//   fire_cnt      number of accepted fires (saturating)
//   late_cnt      number of late timestamps seen (saturating)
// ---------------------------------------------------------------------------
module q_time_scheduler #(
    parameter int TW = 20,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          flush,
    input  logic [TW-1:0] t_cnt,
    input  logic          ts_empty,
    input  logic [TW-1:0] ts_data,
    output logic          ts_rd_en,
    output logic          fire_valid,
    input  logic          fire_ready,
    output logic [TW-1:0] fire_time,
    output logic          fire_late,
    output logic          busy,
    output logic [CW-1:0] fire_cnt,
    output logic [CW-1:0] late_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POP   = 3'd1,
        LOAD  = 3'd2,
        WAIT  = 3'd3,
        ISSUE = 3'd4
    } state_t;

    state_t        state_reg, state_next;
    logic [TW-1:0] cur_time_reg;
    logic          fire_late_reg, fire_late_next;
    logic [CW-1:0] fire_cnt_reg, late_cnt_reg;
    logic          fire_inc, late_inc;

    logic [TW-1:0] diff;
    logic          due, late, fetch_ok;

    // Modular distance to the target time; top bit set means it lies behind t_cnt.
    assign diff     = cur_time_reg - t_cnt;
    assign due      = (diff == '0);
    assign late     = diff[TW-1];
    assign fetch_ok = enable && !ts_empty;

    always_comb begin
        state_next     = state_reg;
        fire_late_next = fire_late_reg;
        fire_inc       = 1'b0;
        late_inc       = 1'b0;

        if (flush) begin
            // Flush overrides everything; counters are left untouched.
            state_next     = IDLE;
            fire_late_next = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (fetch_ok) state_next = POP;
                end
                POP: begin
                    state_next = LOAD;
                end
                LOAD: begin
                    state_next = WAIT;
                end
                WAIT: begin
                    if (due) begin
                        state_next     = ISSUE;
                        fire_late_next = 1'b0;
                    end else if (late) begin
                        late_inc = 1'b1;
`ifdef Q_LATE_DROP_EN
                        state_next = fetch_ok ? POP : IDLE;
`else
                        state_next     = ISSUE;
                        fire_late_next = 1'b1;
`endif
                    end
                end
                ISSUE: begin
                    if (fire_ready) begin
                        fire_inc       = 1'b1;
                        fire_late_next = 1'b0;
                        state_next     = fetch_ok ? POP : IDLE;
                    end
                end
                default: begin
                    state_next     = IDLE;
                    fire_late_next = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            cur_time_reg  <= '0;
            fire_late_reg <= 1'b0;
            fire_cnt_reg  <= '0;
            late_cnt_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            fire_late_reg <= fire_late_next;
            // ts_data answers the pop issued in the previous (POP) cycle.
            if (state_reg == LOAD && !flush) begin
                cur_time_reg <= ts_data;
            end
            if (fire_inc && (fire_cnt_reg != '1)) begin
                fire_cnt_reg <= fire_cnt_reg + 1'b1;
            end
            if (late_inc && (late_cnt_reg != '1)) begin
                late_cnt_reg <= late_cnt_reg + 1'b1;
            end
        end
    end

    // Outputs decode directly from registers, so they are glitch-free and
    // change only on clock edges.
    assign ts_rd_en   = (state_reg == POP);
    assign fire_valid = (state_reg == ISSUE);
    assign fire_time  = cur_time_reg;
    assign fire_late  = fire_late_reg;
    assign busy       = (state_reg != IDLE);
    assign fire_cnt   = fire_cnt_reg;
    assign late_cnt   = late_cnt_reg;

endmodule

// File: tb/tb_q_time_scheduler.sv
// ---------------------------------------------------------------------------
// tb_q_time_scheduler
//
// Directed bench for q_time_scheduler (TW=20, CW=4 so saturation is reachable).
// A small FIFO model answers pops one cycle later; t_cnt is advanced by the
// bench one step per clock. Inputs change and outputs are sampled 1 time unit
// after each rising edge.
// ---------------------------------------------------------------------------
module tb_q_time_scheduler;

    localparam int TW = 20;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          flush;
    logic [TW-1:0] t_cnt;
    logic          ts_empty;
    logic [TW-1:0] ts_data;
    logic          ts_rd_en;
    logic          fire_valid;
    logic          fire_ready;
    logic [TW-1:0] fire_time;
    logic          fire_late;
    logic          busy;
    logic [CW-1:0] fire_cnt;
    logic [CW-1:0] late_cnt;

    logic [TW-1:0] mem [0:63];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    logic          t_run  = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    assign ts_empty = (wr_ptr == rd_ptr);

    always #5 clk = ~clk;

    q_time_scheduler #(.TW(TW), .CW(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .flush      (flush),
        .t_cnt      (t_cnt),
        .ts_empty   (ts_empty),
        .ts_data    (ts_data),
        .ts_rd_en   (ts_rd_en),
        .fire_valid (fire_valid),
        .fire_ready (fire_ready),
        .fire_time  (fire_time),
        .fire_late  (fire_late),
        .busy       (busy),
        .fire_cnt   (fire_cnt),
        .late_cnt   (late_cnt)
    );

    task automatic push(input logic [TW-1:0] v);
        mem[wr_ptr] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    // One clock: the pop strobe seen before the edge delivers data after it.
    task automatic tick();
        logic pop_now;
        pop_now = ts_rd_en;
        @(posedge clk);
        #1;
        if (pop_now) begin
            ts_data = mem[rd_ptr];
            rd_ptr  = rd_ptr + 1;
        end
        if (t_run) t_cnt = t_cnt + 1'b1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-22s observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        flush      = 1'b0;
        fire_ready = 1'b0;
        t_cnt      = '0;
        ts_data    = '0;
        tick();
        tick();
        chk("rst_busy",       32'(busy),       32'd0);
        chk("rst_fire_valid", 32'(fire_valid), 32'd0);
        chk("rst_ts_rd_en",   32'(ts_rd_en),   32'd0);
        chk("rst_fire_time",  32'(fire_time),  32'd0);
        chk("rst_fire_cnt",   32'(fire_cnt),   32'd0);
        reset = 1'b0;
        tick();

        // Timestamp 100, t_cnt=90 at POP: fire the cycle after t_cnt=100.
        t_cnt  = 20'd89;
        push(20'd100);
        enable = 1'b1;
        tick();
        chk("s1_pop_rd_en",   32'(ts_rd_en),   32'd1);
        tick();
        chk("s1_pop_one_cyc", 32'(ts_rd_en),   32'd0);
        repeat (9) tick();
        chk("s1_not_yet",     32'(fire_valid), 32'd0);
        tick();
        chk("s1_fire_valid",  32'(fire_valid), 32'd1);
        chk("s1_fire_time",   32'(fire_time),  32'd100);
        chk("s1_fire_late",   32'(fire_late),  32'd0);
        fire_ready = 1'b1;
        tick();
        fire_ready = 1'b0;
        chk("s1_valid_clr",   32'(fire_valid), 32'd0);
        chk("s1_fire_cnt",    32'(fire_cnt),   32'd1);
        chk("s1_idle",        32'(busy),       32'd0);

        // Due at first WAIT: fire_valid 3 cycles after ts_rd_en; then back-pressure.
        t_cnt = 20'd200;
        push(20'd203);
        push(20'd500);
        tick();
        chk("s2_rd_en",       32'(ts_rd_en),   32'd1);
        tick();
        tick();
        chk("s2_wait",        32'(fire_valid), 32'd0);
        tick();
        chk("s2_fire_valid",  32'(fire_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("s2_hold_valid", 32'(fire_valid), 32'd1);
            chk("s2_hold_time",  32'(fire_time),  32'd203);
            chk("s2_hold_cnt",   32'(fire_cnt),   32'd1);
        end
        fire_ready = 1'b1;
        tick();
        fire_ready = 1'b0;
        chk("s2_valid_clr",   32'(fire_valid), 32'd0);
        chk("s2_fire_cnt",    32'(fire_cnt),   32'd2);
        chk("s2_back_to_pop", 32'(ts_rd_en),   32'd1);

        // Flush in WAIT: no fire, IDLE, next entry fetched only once enabled.
        enable = 1'b0;
        tick();
        tick();
        tick();
        chk("s3_waiting",     32'(busy),       32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("s3_flush_busy",  32'(busy),       32'd0);
        chk("s3_flush_valid", 32'(fire_valid), 32'd0);
        chk("s3_flush_cnt",   32'(fire_cnt),   32'd2);
        push(20'h00005);
        tick();
        chk("s3_no_fetch",    32'(ts_rd_en),   32'd0);

        // Wrap: timestamp 0x00005 with t_cnt near 0xFFFF0 is future, not late.
        t_cnt  = 20'hFFFF0;
        enable = 1'b1;
        tick();
        chk("s4_fetch",       32'(ts_rd_en),   32'd1);
        enable = 1'b0;
        repeat (20) tick();
        chk("s4_pre_wrap",    32'(fire_valid), 32'd0);
        chk("s4_pre_busy",    32'(busy),       32'd1);
        tick();
        chk("s4_fire_valid",  32'(fire_valid), 32'd1);
        chk("s4_fire_time",   32'(fire_time),  32'h00005);
        chk("s4_fire_late",   32'(fire_late),  32'd0);
        fire_ready = 1'b1;
        tick();
        fire_ready = 1'b0;
        chk("s4_fire_cnt",    32'(fire_cnt),   32'd3);

        // Late: timestamp 50 evaluated at t_cnt=60.
        t_cnt  = 20'd57;
        push(20'd50);
        enable = 1'b1;
        tick();
        enable = 1'b0;
        tick();
        tick();
        tick();
`ifdef Q_LATE_DROP_EN
        chk("s5_drop_valid",  32'(fire_valid), 32'd0);
        chk("s5_drop_busy",   32'(busy),       32'd0);
        chk("s5_late_cnt",    32'(late_cnt),   32'd1);
        chk("s5_fire_cnt",    32'(fire_cnt),   32'd3);
`else
        chk("s5_fire_valid",  32'(fire_valid), 32'd1);
        chk("s5_fire_late",   32'(fire_late),  32'd1);
        chk("s5_fire_time",   32'(fire_time),  32'd50);
        chk("s5_late_cnt",    32'(late_cnt),   32'd1);
        fire_ready = 1'b1;
        tick();
        fire_ready = 1'b0;
        chk("s5_late_clr",    32'(fire_late),  32'd0);
        chk("s5_fire_cnt",    32'(fire_cnt),   32'd4);
`endif

        // Saturation: 16 late entries push both counters past 2^CW-1.
        t_cnt = 20'd1000;
        for (int i = 0; i < 16; i++) push(20'd0);
        enable     = 1'b1;
        fire_ready = 1'b1;
        repeat (100) tick();
        chk("s6_late_sat",    32'(late_cnt),   32'd15);
`ifdef Q_LATE_DROP_EN
        chk("s6_fire_cnt",    32'(fire_cnt),   32'd3);
`else
        chk("s6_fire_sat",    32'(fire_cnt),   32'd15);
`endif
        chk("s6_drained",     32'(busy),       32'd0);
        fire_ready = 1'b0;

        // Reset (with flush also high) while firing clears everything.
        t_cnt = 20'd300;
        push(20'd303);
        tick();
        tick();
        tick();
        tick();
        chk("s7_issue",       32'(fire_valid), 32'd1);
        reset = 1'b1;
        flush = 1'b1;
        tick();
        chk("s7_valid",       32'(fire_valid), 32'd0);
        chk("s7_busy",        32'(busy),       32'd0);
        chk("s7_fire_time",   32'(fire_time),  32'd0);
        chk("s7_fire_cnt",    32'(fire_cnt),   32'd0);
        chk("s7_late_cnt",    32'(late_cnt),   32'd0);
        chk("s7_rd_en",       32'(ts_rd_en),   32'd0);
        reset = 1'b0;
        flush = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
